uart_rx_ctrl: RTL and testbench

//  Frame sequencer for the UART receiver. Detects the start condition, runs the oversampling edge/bit counters and

---
 rtl/uart_rx_pkg.sv | 22 ++
 rtl/uart_rx_ctrl_if.sv | 39 +++
 rtl/uart_rx_edge_bit_cnt.sv | 44 ++++
 rtl/uart_rx_ctrl.sv | 147 ++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_pkg
// Brief    : Shared state encoding and timing constants for the UART RX frame sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_e;

    localparam int PRESCALE_MIN = 8;
    // Checker strobes land this many edges past mid-bit, after the majority vote settles.
    localparam int CHK_OFFSET   = 2;

endpackage
`default_nettype wire

// File: rtl/uart_rx_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_ctrl_if
// Brief    : Line, config and checker-result inputs plus strobe/status outputs of the RX sequencer.
// Revision : 1.0 - initial release
// ============================================================================
interface uart_rx_ctrl_if #(
    parameter int PRESCALE_WIDTH = 6
);
    logic                      s_data_in;
    logic [PRESCALE_WIDTH-1:0] prescale_in;
    logic                      par_en_in;
    logic                      strt_glitch_in;
    logic                      par_err_in;
    logic                      stop_err_in;
    logic [PRESCALE_WIDTH-1:0] edge_cnt_out;
    logic                      sample_en_out;
    logic                      strt_chk_en_out;
    logic                      deser_en_out;
    logic                      par_chk_en_out;
    logic                      stop_chk_en_out;
    logic                      data_valid_out;
    logic                      parity_error_out;
    logic                      stop_error_out;
    logic                      busy_out;

    modport master (
        output s_data_in, prescale_in, par_en_in, strt_glitch_in, par_err_in, stop_err_in,
        input  edge_cnt_out, sample_en_out, strt_chk_en_out, deser_en_out, par_chk_en_out,
               stop_chk_en_out, data_valid_out, parity_error_out, stop_error_out, busy_out
    );

    modport slave (
        input  s_data_in, prescale_in, par_en_in, strt_glitch_in, par_err_in, stop_err_in,
        output edge_cnt_out, sample_en_out, strt_chk_en_out, deser_en_out, par_chk_en_out,
               stop_chk_en_out, data_valid_out, parity_error_out, stop_error_out, busy_out
    );
endinterface
`default_nettype wire

// File: rtl/uart_rx_edge_bit_cnt.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_edge_bit_cnt
// Brief    : Oversample edge counter and bit counter; cleared whenever disabled.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_edge_bit_cnt #(
    parameter int EDGE_WIDTH = 6,
    parameter int BIT_WIDTH  = 4
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    input  wire logic                  i_en,
    input  wire logic [EDGE_WIDTH-1:0] i_last_edge,
    output logic      [EDGE_WIDTH-1:0] o_edge_cnt,
    output logic      [BIT_WIDTH-1:0]  o_bit_cnt,
    output logic                       o_wrap
);
    localparam logic [EDGE_WIDTH-1:0] c_edge_one = EDGE_WIDTH'(1);
    localparam logic [BIT_WIDTH-1:0]  c_bit_one  = BIT_WIDTH'(1);

    logic [EDGE_WIDTH-1:0] r_edge_cnt;
    logic [BIT_WIDTH-1:0]  r_bit_cnt;
    logic                  w_wrap;

    assign w_wrap = i_en && (r_edge_cnt == i_last_edge);

    always_ff @(posedge clk) begin
        if (rst || !i_en) begin
            r_edge_cnt <= '0;
            r_bit_cnt  <= '0;
        end else if (w_wrap) begin
            r_edge_cnt <= '0;
            r_bit_cnt  <= r_bit_cnt + c_bit_one;
        end else begin
            r_edge_cnt <= r_edge_cnt + c_edge_one;
        end
    end

    assign o_edge_cnt = r_edge_cnt;
    assign o_bit_cnt  = r_bit_cnt;
    assign o_wrap     = w_wrap;
endmodule
`default_nettype wire

// File: rtl/uart_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_ctrl
// Brief    : UART RX frame sequencer: start detect, checker strobes, frame result pulses.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_ctrl
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6
) (
    input wire logic       rx_clk,
    input wire logic       res,
    uart_rx_ctrl_if.slave  rx_if
);
    localparam int c_bit_width = $clog2(DATA_WIDTH + 4);
    localparam logic [PRESCALE_WIDTH-1:0] c_presc_min   = PRESCALE_WIDTH'(PRESCALE_MIN);
    localparam logic [PRESCALE_WIDTH-1:0] c_one         = PRESCALE_WIDTH'(1);
    localparam logic [PRESCALE_WIDTH-1:0] c_chk_pre_ofs = PRESCALE_WIDTH'(CHK_OFFSET - 1);
    localparam logic [c_bit_width-1:0]    c_last_data   = c_bit_width'(DATA_WIDTH);

    rx_state_e                 r_state;
    logic [PRESCALE_WIDTH-1:0] r_last_edge;
    logic [PRESCALE_WIDTH-1:0] r_chk_pre;
    logic                      r_par_en;
    logic                      r_busy;
    logic                      r_strt_chk;
    logic                      r_deser;
    logic                      r_par_chk;
    logic                      r_stop_chk;
    logic                      r_valid;
    logic                      r_perr;
    logic                      r_serr;

    logic [PRESCALE_WIDTH-1:0] w_prescale;
    logic [PRESCALE_WIDTH-1:0] w_edge_cnt;
    logic [c_bit_width-1:0]    w_bit_cnt;
    logic                      w_wrap;
    logic                      w_cnt_en;
    logic                      w_pre_chk;
    logic                      w_par_err;

    assign w_prescale = (rx_if.prescale_in < c_presc_min) ? c_presc_min : rx_if.prescale_in;
    assign w_cnt_en   = (r_state != IDLE);
    // Strobes are registered, so they are armed one edge ahead of CHK.
    assign w_pre_chk  = (w_edge_cnt == r_chk_pre);
    assign w_par_err  = r_par_en & rx_if.par_err_in;

    uart_rx_edge_bit_cnt #(
        .EDGE_WIDTH (PRESCALE_WIDTH),
        .BIT_WIDTH  (c_bit_width)
    ) u_cnt (
        .clk         (rx_clk),
        .rst         (res),
        .i_en        (w_cnt_en),
        .i_last_edge (r_last_edge),
        .o_edge_cnt  (w_edge_cnt),
        .o_bit_cnt   (w_bit_cnt),
        .o_wrap      (w_wrap)
    );

    always_ff @(posedge rx_clk) begin
        if (res) begin
            r_state     <= IDLE;
            r_last_edge <= '0;
            r_chk_pre   <= '0;
            r_par_en    <= 1'b0;
            r_busy      <= 1'b0;
            r_strt_chk  <= 1'b0;
            r_deser     <= 1'b0;
            r_par_chk   <= 1'b0;
            r_stop_chk  <= 1'b0;
            r_valid     <= 1'b0;
            r_perr      <= 1'b0;
            r_serr      <= 1'b0;
        end else begin
            r_strt_chk <= 1'b0;
            r_deser    <= 1'b0;
            r_par_chk  <= 1'b0;
            r_stop_chk <= 1'b0;
            r_valid    <= 1'b0;
            r_perr     <= 1'b0;
            r_serr     <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (!rx_if.s_data_in) begin
                        r_state     <= START;
                        r_busy      <= 1'b1;
                        r_last_edge <= w_prescale - c_one;
                        r_chk_pre   <= (w_prescale >> 1) + c_chk_pre_ofs;
                        r_par_en    <= rx_if.par_en_in;
                    end
                end
                START: begin
                    r_strt_chk <= w_pre_chk;
                    if (w_wrap) begin
                        if (rx_if.strt_glitch_in) begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state <= DATA;
                        end
                    end
                end
                DATA: begin
                    r_deser <= w_pre_chk;
                    if (w_wrap && (w_bit_cnt == c_last_data)) begin
                        r_state <= r_par_en ? PARITY : STOP;
                    end
                end
                PARITY: begin
                    r_par_chk <= w_pre_chk;
                    if (w_wrap) begin
                        r_state <= STOP;
                    end
                end
                STOP: begin
                    r_stop_chk <= w_pre_chk;
                    if (w_wrap) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_valid <= !w_par_err && !rx_if.stop_err_in;
                        r_perr  <= w_par_err;
                        r_serr  <= rx_if.stop_err_in;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign rx_if.edge_cnt_out     = w_edge_cnt;
    assign rx_if.sample_en_out    = r_busy;
    assign rx_if.busy_out         = r_busy;
    assign rx_if.strt_chk_en_out  = r_strt_chk;
    assign rx_if.deser_en_out     = r_deser;
    assign rx_if.par_chk_en_out   = r_par_chk;
    assign rx_if.stop_chk_en_out  = r_stop_chk;
    assign rx_if.data_valid_out   = r_valid;
    assign rx_if.parity_error_out = r_perr;
    assign rx_if.stop_error_out   = r_serr;
endmodule
`default_nettype wire

// File: tb/tb_uart_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_ctrl
// Brief    : Frame-table and scoreboard bench for the UART RX frame sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_ctrl;
    localparam int DW = 8;
    localparam int PW = 6;

    typedef struct {
        int cyc;
        int kind;
    } ev_t;

    typedef struct {
        int presc;
        bit par;
        bit glitch;
        bit perr;
        bit serr;
        int presc_mid;
        int rst_at;
        int exp_done;
        bit exp_valid;
        bit exp_perr;
        bit exp_serr;
    } vec_t;

    logic rx_clk = 1'b0;
    logic res    = 1'b1;
    int   cyc    = 0;
    int   total  = 0;
    int   bad    = 0;
    int   busy_lo = 0;
    int   busy_hi = 0;
    int   exp_p   = 8;
    ev_t  q[$];
    vec_t tbl[10];

    uart_rx_ctrl_if #(.PRESCALE_WIDTH(PW)) bus ();

    uart_rx_ctrl #(
        .DATA_WIDTH     (DW),
        .PRESCALE_WIDTH (PW)
    ) dut (
        .rx_clk (rx_clk),
        .res    (res),
        .rx_if  (bus)
    );

    always #5 rx_clk = ~rx_clk;
    always @(posedge rx_clk) cyc <= cyc + 1;

    function automatic string kname(input int k);
        case (k)
            0: return "strt_chk_en";
            1: return "deser_en";
            2: return "par_chk_en";
            3: return "stop_chk_en";
            4: return "data_valid";
            5: return "parity_error";
            default: return "stop_error";
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad < 60) $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic mon();
        logic       eb;
        logic [6:0] p;
        int         e_edge;
        int         found;
        eb     = (cyc >= busy_lo) && (cyc < busy_hi);
        e_edge = eb ? (cyc - busy_lo) % exp_p : 0;
        chk("busy_out", {31'd0, bus.busy_out}, {31'd0, eb});
        chk("sample_en_out", {31'd0, bus.sample_en_out}, {31'd0, eb});
        chk("edge_cnt_out", {26'd0, bus.edge_cnt_out}, e_edge);
        p = {bus.stop_error_out, bus.parity_error_out, bus.data_valid_out, bus.stop_chk_en_out,
             bus.par_chk_en_out, bus.deser_en_out, bus.strt_chk_en_out};
        for (int k = 0; k < 7; k++) begin
            if (p[k] !== 1'b0) begin
                found = -1;
                for (int i = 0; i < q.size(); i++)
                    if (found < 0 && q[i].cyc == cyc && q[i].kind == k) found = i;
                total++;
                if (found < 0) begin
                    bad++;
                    if (bad < 60) $display("FAIL %s cyc=%0d got=%b want=0", kname(k), cyc, p[k]);
                end else begin
                    q.delete(found);
                end
            end
        end
        while (q.size() > 0 && q[0].cyc < cyc) begin
            total++;
            bad++;
            if (bad < 60) $display("FAIL %s cyc=%0d got=0 want=1", kname(q[0].kind), q[0].cyc);
            void'(q.pop_front());
        end
    endtask

    always @(posedge rx_clk) begin
        #1;
        mon();
    end

    function automatic vec_t mk(input int presc, input bit par, input bit g, input bit pe, input bit se,
                                input int done, input bit ev, input bit ep, input bit es);
        vec_t v;
        v.presc = presc; v.par = par; v.glitch = g; v.perr = pe; v.serr = se;
        v.presc_mid = 0; v.rst_at = 0; v.exp_done = done;
        v.exp_valid = ev; v.exp_perr = ep; v.exp_serr = es;
        return v;
    endfunction

    task automatic push(input int c, input int k);
        ev_t e;
        e.cyc  = c;
        e.kind = k;
        q.push_back(e);
    endtask

    // Called on a falling edge; the line is driven low for the current cycle.
    task automatic play(input vec_t v);
        int t0, s, p, c, pe, n_end;
        t0 = cyc;
        p  = (v.presc < 8) ? 8 : v.presc;
        c  = p / 2 + 2;
        s  = t0 + 1;
        pe = v.par ? 1 : 0;
        push(s + c, 0);
        if (!v.glitch) begin
            for (int i = 0; i < DW; i++) push(s + p * (1 + i) + c, 1);
            if (v.par) push(s + p * (1 + DW) + c, 2);
            push(s + p * (1 + DW + pe) + c, 3);
        end
        if (v.exp_valid) push(t0 + v.exp_done, 4);
        if (v.exp_perr)  push(t0 + v.exp_done, 5);
        if (v.exp_serr)  push(t0 + v.exp_done, 6);
        busy_lo = s;
        busy_hi = t0 + ((v.rst_at > 0) ? v.rst_at + 1 : v.exp_done);
        exp_p   = p;
        n_end   = t0 + v.exp_done;
        bus.prescale_in    = PW'(v.presc);
        bus.par_en_in      = v.par;
        bus.strt_glitch_in = v.glitch;
        bus.par_err_in     = v.perr;
        bus.stop_err_in    = v.serr;
        for (int n = t0; n < n_end; n++) begin
            if (n == t0)
                bus.s_data_in = 1'b0;
            else if (n >= s + p && n < s + p * (1 + DW + pe))
                bus.s_data_in = 1'($urandom_range(1, 0));
            else
                bus.s_data_in = 1'b1;
            if (n == t0 + 20) bus.par_en_in = !v.par;
            if (v.presc_mid != 0 && n == t0 + 40) bus.prescale_in = PW'(v.presc_mid);
            if (v.rst_at > 0 && n >= t0 + v.rst_at) begin
                res = 1'b1;
                if (n == t0 + v.rst_at)
                    while (q.size() > 0 && q[$].cyc > n) void'(q.pop_back());
            end
            @(negedge rx_clk);
        end
        res           = 1'b0;
        bus.s_data_in = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            bus.s_data_in = 1'b1;
            @(negedge rx_clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        tbl[0] = mk(8,  1, 0, 0, 0, 89,  1, 0, 0);
        tbl[1] = mk(8,  1, 1, 0, 0, 9,   0, 0, 0);
        tbl[2] = mk(16, 0, 0, 0, 0, 161, 1, 0, 0);
        tbl[3] = mk(8,  1, 0, 1, 0, 89,  0, 1, 0);
        tbl[4] = mk(8,  1, 0, 0, 1, 89,  0, 0, 1);
        tbl[5] = mk(8,  1, 0, 1, 1, 89,  0, 1, 1);
        tbl[6] = mk(8,  0, 0, 1, 0, 81,  1, 0, 0);
        tbl[7] = mk(4,  0, 0, 0, 0, 81,  1, 0, 0);
        tbl[8] = mk(32, 0, 0, 0, 1, 321, 0, 0, 1);
        tbl[9] = mk(16, 1, 1, 1, 1, 17,  0, 0, 0);

        bus.s_data_in      = 1'b1;
        bus.prescale_in    = PW'(8);
        bus.par_en_in      = 1'b0;
        bus.strt_glitch_in = 1'b0;
        bus.par_err_in     = 1'b0;
        bus.stop_err_in    = 1'b0;
        res                = 1'b1;
        repeat (3) @(negedge rx_clk);
        chk("rst_edge_cnt",     {26'd0, bus.edge_cnt_out}, 0);
        chk("rst_sample_en",    {31'd0, bus.sample_en_out}, 0);
        chk("rst_strt_chk",     {31'd0, bus.strt_chk_en_out}, 0);
        chk("rst_deser_en",     {31'd0, bus.deser_en_out}, 0);
        chk("rst_par_chk",      {31'd0, bus.par_chk_en_out}, 0);
        chk("rst_stop_chk",     {31'd0, bus.stop_chk_en_out}, 0);
        chk("rst_data_valid",   {31'd0, bus.data_valid_out}, 0);
        chk("rst_parity_error", {31'd0, bus.parity_error_out}, 0);
        chk("rst_stop_error",   {31'd0, bus.stop_error_out}, 0);
        chk("rst_busy",         {31'd0, bus.busy_out}, 0);
        res = 1'b0;
        idle(2);

        for (int i = 0; i < 10; i++) begin
            play(tbl[i]);
            idle(5);
        end

        // Reset held two cycles in the middle of the data bits, then a clean frame.
        v = mk(8, 1, 0, 0, 0, 32, 0, 0, 0);
        v.rst_at = 30;
        play(v);
        idle(3);
        play(tbl[0]);
        idle(3);

        // Back-to-back frames with prescale raised mid-way through the first one.
        v = mk(8, 1, 0, 0, 0, 89, 1, 0, 0);
        v.presc_mid = 16;
        play(v);
        play(mk(16, 1, 0, 0, 0, 177, 1, 0, 0));
        idle(10);

        chk("scoreboard_empty", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
